// File: rtl/flash_period_ctrl.sv
// flash_period_ctrl
//
// Front-panel timing controller for the LED flasher. The three active-low KEY
// pushbuttons are synchronized and debounced. Clean button events adjust the
// flash period, and a TICK strobe is produced once every PERIOD clocks.
//
// Ports:
//   CLOCK_50  in   1   system clock, rising-edge
//   RESET_N   in   1   asynchronous reset, active-low
//   KEY       in   3   raw buttons, active-low: [0] slow down, [1] speed up,
//                      [2] restore default
//   PERIOD    out  32  current flash period in clock cycles
//   TICK      out  1   one-cycle strobe at the end of each period
//   EVT       out  3   one-cycle pulse per accepted event, bit index = KEY index
//   AT_MIN    out  1   PERIOD == PERIOD_MIN
//   AT_MAX    out  1   PERIOD == PERIOD_MAX
module flash_period_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PERIOD_DEFAULT  = 25000000,
  parameter int unsigned PERIOD_STEP     = 12500000,
  parameter int unsigned PERIOD_MIN      = 12500000,
  parameter int unsigned PERIOD_MAX      = 100000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [2:0]  KEY,
  output logic [31:0] PERIOD,
  output logic        TICK,
  output logic [2:0]  EVT,
  output logic        AT_MIN,
  output logic        AT_MAX
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge where the count would reach DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            deb;
  logic [2:0]            deb_q;
  logic [2:0][CNT_W-1:0] db_cnt;
  logic [31:0]           tick_cnt;

  logic        ev_slow;
  logic        ev_fast;
  logic        ev_dflt;
  logic [32:0] slow_sum;
  logic [32:0] fast_diff;
  logic        slow_ok;
  logic        fast_ok;
  logic        apply;
  logic [31:0] next_period;
  logic [2:0]  next_evt;

  // ---- stage: two-flop synchronizer, released level is 1
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  // ---- stage: per-key debounce; deb_q holds last cycle's level for edge detection
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb    <= 3'b111;
      deb_q  <= 3'b111;
      db_cnt <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Slow/fast act on release, default acts on press.
  assign ev_slow = deb[0] & ~deb_q[0];
  assign ev_fast = deb[1] & ~deb_q[1];
  assign ev_dflt = ~deb[2] & deb_q[2];

  // 33-bit range checks: a borrow out of the subtraction lands in bit 32.
  assign slow_sum  = {1'b0, PERIOD} + 33'(PERIOD_STEP);
  assign fast_diff = {1'b0, PERIOD} - 33'(PERIOD_STEP);
  assign slow_ok   = (slow_sum <= 33'(PERIOD_MAX));
  assign fast_ok   = !fast_diff[32] && (fast_diff >= 33'(PERIOD_MIN));

  // Priority pick: default, then slow, then fast. A selected but rejected
  // event still blocks the lower-priority one; nothing is queued. Slow/fast
  // are ignored while the default key is held down.
  always_comb begin
    apply       = 1'b0;
    next_period = PERIOD;
    next_evt    = 3'b000;
    if (ev_dflt) begin
      apply       = 1'b1;
      next_period = 32'(PERIOD_DEFAULT);
      next_evt    = 3'b100;
    end else if (deb[2]) begin
      if (ev_slow) begin
        if (slow_ok) begin
          apply       = 1'b1;
          next_period = slow_sum[31:0];
          next_evt    = 3'b001;
        end
      end else if (ev_fast) begin
        if (fast_ok) begin
          apply       = 1'b1;
          next_period = fast_diff[31:0];
          next_evt    = 3'b010;
        end
      end
    end
  end

  // ---- stage: period register and tick counter
  // An applied event restarts the count so the next TICK lands exactly one
  // new period after the change.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      PERIOD   <= 32'(PERIOD_DEFAULT);
      EVT      <= 3'b000;
      TICK     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      PERIOD <= next_period;
      EVT    <= next_evt;
      if (apply) begin
        tick_cnt <= '0;
        TICK     <= 1'b0;
      end else if (tick_cnt == PERIOD - 32'd1) begin
        tick_cnt <= '0;
        TICK     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
        TICK     <= 1'b0;
      end
    end
  end

  assign AT_MIN = (PERIOD == 32'(PERIOD_MIN));
  assign AT_MAX = (PERIOD == 32'(PERIOD_MAX));

endmodule

// File: tb/tb_flash_period_ctrl.sv
// Directed bench for flash_period_ctrl with small timing parameters.
// Cycle numbers e count rising edges after reset release (first edge = 1);
// KEY is set just before edge e and outputs are sampled 1 ns after it.
module tb_flash_period_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic [2:0]  KEY      = 3'b111;
  logic [31:0] PERIOD;
  logic        TICK;
  logic [2:0]  EVT;
  logic        AT_MIN;
  logic        AT_MAX;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_per;
  logic        exp_tick;
  logic [2:0]  exp_evt;
  logic        exp_mn;
  logic        exp_mx;

  flash_period_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PERIOD_DEFAULT (8),
    .PERIOD_STEP    (4),
    .PERIOD_MIN     (4),
    .PERIOD_MAX     (16)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .KEY     (KEY),
    .PERIOD  (PERIOD),
    .TICK    (TICK),
    .EVT     (EVT),
    .AT_MIN  (AT_MIN),
    .AT_MAX  (AT_MAX)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    KEY     = 3'b111;
    step();
    step();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    KEY     = 3'b111;
    step();
    step();
    vectors++;
    if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {32'd8, 1'b0, 3'b000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold: got P=%0d T=%b E=%b mn=%b mx=%b, want P=8 T=0 E=000 mn=0 mx=0",
               PERIOD, TICK, EVT, AT_MIN, AT_MAX);
    end
    RESET_N = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      exp_tick = (e == 8 || e == 16 || e == 24);
      vectors++;
      if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {32'd8, exp_tick, 3'b000, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_tick e=%0d: got P=%0d T=%b E=%b mn=%b mx=%b, want P=8 T=%b E=000 mn=0 mx=0",
                 e, PERIOD, TICK, EVT, AT_MIN, AT_MAX, exp_tick);
      end
    end
  endtask

  task automatic test_slow();
    do_reset();
    for (int e = 1; e <= 42; e++) begin
      KEY[0] = (e <= 10) ? 1'b0 : 1'b1;
      step();
      exp_per  = (e >= 17) ? 32'd12 : 32'd8;
      exp_tick = (e == 8 || e == 16 || e == 29 || e == 41);
      exp_evt  = (e == 17) ? 3'b001 : 3'b000;
      vectors++;
      if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {exp_per, exp_tick, exp_evt, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL slow e=%0d: got P=%0d T=%b E=%b mn=%b mx=%b, want P=%0d T=%b E=%b mn=0 mx=0",
                 e, PERIOD, TICK, EVT, AT_MIN, AT_MAX, exp_per, exp_tick, exp_evt);
      end
    end
  endtask

  task automatic test_saturate_max();
    do_reset();
    for (int e = 1; e <= 72; e++) begin
      KEY[0] = (((e - 1) % 20) < 10) ? 1'b0 : 1'b1;
      step();
      exp_per  = (e >= 37) ? 32'd16 : ((e >= 17) ? 32'd12 : 32'd8);
      exp_tick = (e == 8 || e == 16 || e == 29 || e == 53 || e == 69);
      exp_evt  = (e == 17 || e == 37) ? 3'b001 : 3'b000;
      exp_mx   = (e >= 37);
      vectors++;
      if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {exp_per, exp_tick, exp_evt, 1'b0, exp_mx}) begin
        miscompares++;
        $display("FAIL max e=%0d: got P=%0d T=%b E=%b mn=%b mx=%b, want P=%0d T=%b E=%b mn=0 mx=%b",
                 e, PERIOD, TICK, EVT, AT_MIN, AT_MAX, exp_per, exp_tick, exp_evt, exp_mx);
      end
    end
    KEY = 3'b111;
  endtask

  task automatic test_glitch_min();
    do_reset();
    for (int e = 1; e <= 72; e++) begin
      KEY[1] = ((e <= 2) || (e >= 11 && e <= 13) || (e >= 17 && e <= 19) ||
                (e >= 31 && e <= 40) || (e >= 51 && e <= 60)) ? 1'b0 : 1'b1;
      step();
      exp_per  = (e >= 47) ? 32'd4 : 32'd8;
      exp_tick = (e == 8 || e == 16 || e == 24 || e == 32 || e == 40 || e == 51 ||
                  e == 55 || e == 59 || e == 63 || e == 67 || e == 71);
      exp_evt  = (e == 47) ? 3'b010 : 3'b000;
      exp_mn   = (e >= 47);
      vectors++;
      if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {exp_per, exp_tick, exp_evt, exp_mn, 1'b0}) begin
        miscompares++;
        $display("FAIL min e=%0d: got P=%0d T=%b E=%b mn=%b mx=%b, want P=%0d T=%b E=%b mn=%b mx=0",
                 e, PERIOD, TICK, EVT, AT_MIN, AT_MAX, exp_per, exp_tick, exp_evt, exp_mn);
      end
    end
    KEY = 3'b111;
  endtask

  task automatic test_priority();
    do_reset();
    for (int e = 1; e <= 100; e++) begin
      KEY[0] = ((e <= 10) || (e >= 21 && e <= 30) || (e >= 41 && e <= 50) ||
                (e >= 61 && e <= 70)) ? 1'b0 : 1'b1;
      KEY[2] = (e >= 51 && e <= 90) ? 1'b0 : 1'b1;
      step();
      if (e < 17)      exp_per = 32'd8;
      else if (e < 37) exp_per = 32'd12;
      else if (e < 57) exp_per = 32'd16;
      else             exp_per = 32'd8;
      exp_tick = (e == 8 || e == 16 || e == 29 || e == 53 || e == 65 || e == 73 ||
                  e == 81 || e == 89 || e == 97);
      if (e == 17 || e == 37) exp_evt = 3'b001;
      else if (e == 57)       exp_evt = 3'b100;
      else                    exp_evt = 3'b000;
      exp_mx = (e >= 37 && e < 57);
      vectors++;
      if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {exp_per, exp_tick, exp_evt, 1'b0, exp_mx}) begin
        miscompares++;
        $display("FAIL prio e=%0d: got P=%0d T=%b E=%b mn=%b mx=%b, want P=%0d T=%b E=%b mn=0 mx=%b",
                 e, PERIOD, TICK, EVT, AT_MIN, AT_MAX, exp_per, exp_tick, exp_evt, exp_mx);
      end
    end
    KEY = 3'b111;
  endtask

  task automatic test_async_reset();
    do_reset();
    // Raise PERIOD to 12, then stop with the counter at 5 and KEY[0] mid-debounce.
    for (int e = 1; e <= 22; e++) begin
      KEY[0] = ((e <= 10) || (e >= 20)) ? 1'b0 : 1'b1;
      step();
      exp_per  = (e >= 17) ? 32'd12 : 32'd8;
      exp_tick = (e == 8 || e == 16);
      exp_evt  = (e == 17) ? 3'b001 : 3'b000;
      vectors++;
      if ({PERIOD, TICK, EVT} !== {exp_per, exp_tick, exp_evt}) begin
        miscompares++;
        $display("FAIL pre_reset e=%0d: got P=%0d T=%b E=%b, want P=%0d T=%b E=%b",
                 e, PERIOD, TICK, EVT, exp_per, exp_tick, exp_evt);
      end
    end
    #1;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if ({PERIOD, TICK, EVT, AT_MIN, AT_MAX} !== {32'd8, 1'b0, 3'b000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got P=%0d T=%b E=%b mn=%b mx=%b, want P=8 T=0 E=000 mn=0 mx=0",
               PERIOD, TICK, EVT, AT_MIN, AT_MAX);
    end
    step();
    step();
    RESET_N = 1'b1;
    // KEY[0] stays low across reset and is released after edge 10.
    for (int e = 1; e <= 20; e++) begin
      KEY[0] = (e <= 10) ? 1'b0 : 1'b1;
      step();
      exp_per  = (e >= 17) ? 32'd12 : 32'd8;
      exp_tick = (e == 8 || e == 16);
      exp_evt  = (e == 17) ? 3'b001 : 3'b000;
      vectors++;
      if ({PERIOD, TICK, EVT} !== {exp_per, exp_tick, exp_evt}) begin
        miscompares++;
        $display("FAIL post_reset e=%0d: got P=%0d T=%b E=%b, want P=%0d T=%b E=%b",
                 e, PERIOD, TICK, EVT, exp_per, exp_tick, exp_evt);
      end
    end
    KEY = 3'b111;
  endtask

  initial begin
    test_reset();
    test_slow();
    test_saturate_max();
    test_glitch_min();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
